// File: rtl/lc3_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// lc3_mem_ctrl_if
// Datapath-side memory bus between the LC-3 datapath/sequencer and the
// memory/IO controller.
//   mem_en  : access request (MEM.EN), held by the sequencer until ready
//   mem_we  : 1 = write, 0 = read (R.W)
//   addr    : MAR value
//   wdata   : MDR value to write
//   rdata   : read data returned to the MDR input
//   ready   : R bit, one-cycle pulse marking access completion
// Modports: master = datapath/sequencer, slave = memory controller.
// -----------------------------------------------------------------------------
interface lc3_mem_ctrl_if;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ready;

   modport master (
      output mem_en, mem_we, addr, wdata,
      input  rdata, ready
   );

   modport slave (
      input  mem_en, mem_we, addr, wdata,
      output rdata, ready
   );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lc3_mem_ctrl
// Memory/IO controller for the LC-3 datapath. Accepts one access at a time from
// the datapath bus, runs a synchronous SRAM cycle with programmable wait states
// for addresses below xFE00, and serves the xFE00-xFFFF device page (KBSR, KBDR,
// DSR, DDR, MCR) directly. Raises keyboard/display interrupt requests.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   bus               : datapath bus (slave side): mem_en/mem_we/addr/wdata in,
//                       rdata/ready out
//   sram_cs/we/addr/wdata, sram_rdata : external synchronous SRAM
//   kb_valid/kb_data/kb_ready          : keyboard character handshake
//   dsp_valid/dsp_data/dsp_ready       : display character handshake
//   kb_int, dsp_int   : interrupt requests (status ready AND IE)
//   mcr_run           : MCR[15], clock enable to the core
// -----------------------------------------------------------------------------
module lc3_mem_ctrl #(
   parameter int unsigned RD_WAIT = 2,
   parameter int unsigned WR_WAIT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   lc3_mem_ctrl_if.slave       bus,
   output logic                sram_cs,
   output logic                sram_we,
   output logic [15:0]         sram_addr,
   output logic [15:0]         sram_wdata,
   input  logic [15:0]         sram_rdata,
   input  logic                kb_valid,
   input  logic [7:0]          kb_data,
   output logic                kb_ready,
   output logic                dsp_valid,
   output logic [7:0]          dsp_data,
   input  logic                dsp_ready,
   output logic                kb_int,
   output logic                dsp_int,
   output logic                mcr_run
);

   localparam int unsigned CNT_W = 8;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;
   localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

   typedef enum logic [1:0] {
      IDLE,
      SRAM_WAIT,
      DONE
   } state_e;

   state_e             state_q,      state_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic               ready_q,      ready_d;
   logic [15:0]        rdata_q,      rdata_d;
   logic               sram_cs_q,    sram_cs_d;
   logic               sram_we_q,    sram_we_d;
   logic [15:0]        sram_addr_q,  sram_addr_d;
   logic [15:0]        sram_wdata_q, sram_wdata_d;
   logic               kbsr_rdy_q,   kbsr_rdy_d;
   logic               kbsr_ie_q,    kbsr_ie_d;
   logic [7:0]         kbdr_q,       kbdr_d;
   logic               dsr_rdy_q,    dsr_rdy_d;
   logic               dsr_ie_q,     dsr_ie_d;
   logic [7:0]         dsp_data_q,   dsp_data_d;
   logic               dsp_valid_q,  dsp_valid_d;
   logic               mcr_run_q,    mcr_run_d;

   logic [15:0]        io_rdata;

   // Device-page read mux; unused bits and unmapped addresses read 0.
   always_comb begin
      io_rdata = 16'h0000;
      unique case (bus.addr)
         ADDR_KBSR: io_rdata = {kbsr_rdy_q, kbsr_ie_q, 14'h0000};
         ADDR_KBDR: io_rdata = {8'h00, kbdr_q};
         ADDR_DSR:  io_rdata = {dsr_rdy_q, dsr_ie_q, 14'h0000};
         ADDR_DDR:  io_rdata = {8'h00, dsp_data_q};
         ADDR_MCR:  io_rdata = {mcr_run_q, 15'h0000};
         default:   io_rdata = 16'h0000;
      endcase
   end

   always_comb begin
      // NOTE: every _d gets a default before any branch so no latch is inferred.
      state_d      = state_q;
      cnt_d        = cnt_q;
      ready_d      = 1'b0;
      rdata_d      = rdata_q;
      sram_cs_d    = sram_cs_q;
      sram_we_d    = sram_we_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      kbsr_rdy_d   = kbsr_rdy_q;
      kbsr_ie_d    = kbsr_ie_q;
      kbdr_d       = kbdr_q;
      dsr_rdy_d    = dsr_rdy_q;
      dsr_ie_d     = dsr_ie_q;
      dsp_data_d   = dsp_data_q;
      dsp_valid_d  = dsp_valid_q;
      mcr_run_d    = mcr_run_q;

      unique case (state_q)
         IDLE: begin
            if (bus.mem_en) begin
               if (bus.addr >= 16'hFE00) begin
                  // Device accesses commit on the edge entering DONE so the
                  // result is visible together with the ready pulse.
                  state_d = DONE;
                  ready_d = 1'b1;
                  if (!bus.mem_we) begin
                     rdata_d = io_rdata;
                     if (bus.addr == ADDR_KBDR) kbsr_rdy_d = 1'b0;
                  end else begin
                     unique case (bus.addr)
                        ADDR_KBSR: kbsr_ie_d = bus.wdata[14];
                        ADDR_DSR:  dsr_ie_d  = bus.wdata[14];
                        ADDR_DDR: begin
                           if (dsr_rdy_q) begin
                              dsp_data_d  = bus.wdata[7:0];
                              dsp_valid_d = 1'b1;
                              dsr_rdy_d   = 1'b0;
                           end
                        end
                        ADDR_MCR:  mcr_run_d = bus.wdata[15];
                        default:   ;
                     endcase
                  end
               end else begin
                  state_d      = SRAM_WAIT;
                  sram_cs_d    = 1'b1;
                  sram_we_d    = bus.mem_we;
                  sram_addr_d  = bus.addr;
                  sram_wdata_d = bus.wdata;
                  cnt_d        = bus.mem_we ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
               end
            end
         end
         SRAM_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d   = DONE;
               ready_d   = 1'b1;
               sram_cs_d = 1'b0;
               sram_we_d = 1'b0;
               if (!sram_we_q) rdata_d = sram_rdata;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Device handshakes come after the bus access so a KBDR read cannot
      // cancel a capture taken in the same cycle (only possible when empty).
      if (kb_valid && !kbsr_rdy_q) begin
         kbdr_d     = kb_data;
         kbsr_rdy_d = 1'b1;
      end
      if (dsp_valid_q && dsp_ready) begin
         dsp_valid_d = 1'b0;
         dsr_rdy_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         rdata_q      <= 16'h0000;
         sram_cs_q    <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= 16'h0000;
         sram_wdata_q <= 16'h0000;
         kbsr_rdy_q   <= 1'b0;
         kbsr_ie_q    <= 1'b0;
         kbdr_q       <= 8'h00;
         dsr_rdy_q    <= 1'b1;
         dsr_ie_q     <= 1'b0;
         dsp_data_q   <= 8'h00;
         dsp_valid_q  <= 1'b0;
         mcr_run_q    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ready_q      <= ready_d;
         rdata_q      <= rdata_d;
         sram_cs_q    <= sram_cs_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         kbsr_rdy_q   <= kbsr_rdy_d;
         kbsr_ie_q    <= kbsr_ie_d;
         kbdr_q       <= kbdr_d;
         dsr_rdy_q    <= dsr_rdy_d;
         dsr_ie_q     <= dsr_ie_d;
         dsp_data_q   <= dsp_data_d;
         dsp_valid_q  <= dsp_valid_d;
         mcr_run_q    <= mcr_run_d;
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.ready  = ready_q;
   assign sram_cs    = sram_cs_q;
   assign sram_we    = sram_we_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign kb_ready   = ~kbsr_rdy_q;
   assign dsp_valid  = dsp_valid_q;
   assign dsp_data   = dsp_data_q;
   assign kb_int     = kbsr_rdy_q & kbsr_ie_q;
   assign dsp_int    = dsr_rdy_q & dsr_ie_q;
   assign mcr_run    = mcr_run_q;

endmodule
